led_fader: RTL and testbench



---
 rtl/led_fader.sv | 148 ++++++++++++++
 tb/tb_led_fader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_fader.sv
// led_fader: turns the slow on/off blink request into a PWM-driven LED that
// fades linearly up while the request is high and down while it is low.
// Blocks: request register, step prescaler, 4-state ramp FSM with level
// register, free-running PWM counter with period-boundary duty latch.
// Optional build macro LED_FADER_GAMMA_EN: square-law level-to-duty mapping
// (full-on preserved). Without it the duty equals the level directly.
module led_fader #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_in,
  output logic                led_out,
  output logic [PWM_BITS-1:0] level,
  output logic                busy
);

  localparam int PRESC_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX_LEVEL  = '1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  localparam logic [1:0] S_OFF  = 2'd0;
  localparam logic [1:0] S_UP   = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;
  localparam logic [1:0] S_DOWN = 2'd3;

  // One brightness step in the requested direction, clamped at both ends.
  function automatic logic [PWM_BITS-1:0] step_level(
    input logic [PWM_BITS-1:0] cur,
    input logic                up
  );
    if (up) begin
      return (cur == MAX_LEVEL) ? cur : cur + 1'b1;
    end
    return (cur == '0) ? cur : cur - 1'b1;
  endfunction

  // Brightness level to PWM duty.
  function automatic logic [PWM_BITS-1:0] map_duty(
    input logic [PWM_BITS-1:0] cur
  );
`ifdef LED_FADER_GAMMA_EN
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, cur} * {{PWM_BITS{1'b0}}, cur};
    return (cur == MAX_LEVEL) ? MAX_LEVEL : sq[2*PWM_BITS-1:PWM_BITS];
`else
    return cur;
`endif
  endfunction

  logic                req_q;
  logic [1:0]          state;
  logic [1:0]          state_next;
  logic [PWM_BITS-1:0] level_next;
  logic                presc_clr;
  logic [PRESC_W-1:0]  presc;
  logic                step_tick;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic [PWM_BITS-1:0] level_up;
  logic [PWM_BITS-1:0] level_dn;

  assign step_tick = (presc == PRESC_LAST);
  assign level_up  = step_level(level, 1'b1);
  assign level_dn  = step_level(level, 1'b0);

  // Ramp FSM: a direction reversal takes priority over a step in that cycle.
  always_comb begin
    state_next = state;
    level_next = level;
    presc_clr  = 1'b0;
    case (state)
      S_OFF: begin
        level_next = '0;
        if (req_q) begin
          state_next = S_UP;
          presc_clr  = 1'b1;
        end
      end
      S_UP: begin
        if (!req_q) begin
          state_next = S_DOWN;
        end else if (step_tick) begin
          level_next = level_up;
          if (level_up == MAX_LEVEL) state_next = S_ON;
        end
      end
      S_ON: begin
        level_next = MAX_LEVEL;
        if (!req_q) begin
          state_next = S_DOWN;
          presc_clr  = 1'b1;
        end
      end
      S_DOWN: begin
        if (req_q) begin
          state_next = S_UP;
        end else if (step_tick) begin
          level_next = level_dn;
          if (level_dn == '0) state_next = S_OFF;
        end
      end
      default: begin
        state_next = S_OFF;
        level_next = '0;
      end
    endcase
  end

  // Request register, FSM state, level and busy flag (busy tracks state exactly).
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q <= 1'b0;
      state <= S_OFF;
      level <= '0;
      busy  <= 1'b0;
    end else begin
      req_q <= req_in;
      state <= state_next;
      level <= level_next;
      busy  <= (state_next == S_UP) || (state_next == S_DOWN);
    end
  end

  // Step prescaler; restarts only when a fresh ramp begins from OFF or ON.
  always_ff @(posedge clk) begin
    if (rst || presc_clr || step_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // PWM: duty reloads only at the period boundary so a pulse is never cut short.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt <= '0;
      duty    <= '0;
      led_out <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == MAX_LEVEL) duty <= map_duty(level);
      led_out <= (pwm_cnt < duty) || (duty == MAX_LEVEL);
    end
  end

endmodule

// File: tb/tb_led_fader.sv
// Testbench for led_fader. Two instances (PWM_BITS=4): dut_a with a fast
// step rate for ramp/reversal/reset sequences, dut_b with a slow step rate
// so a brightness level stays put long enough to measure its PWM duty.
module tb_led_fader;

  localparam int PB   = 4;
  localparam int MX   = 15;
  localparam int SD_A = 4;
  localparam int SD_B = 64;
`ifdef LED_FADER_GAMMA_EN
  localparam int EXP_HI5 = 1;
  localparam int EXP_HI8 = 4;
`else
  localparam int EXP_HI5 = 5;
  localparam int EXP_HI8 = 8;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, req_a = 1'b0;
  logic rst_b = 1'b1, req_b = 1'b0;
  logic led_a, busy_a, led_b, busy_b;
  logic [PB-1:0] level_a, level_b;

  int checks   = 0;
  int failures = 0;
  bit armed    = 1'b0;

  led_fader #(.PWM_BITS(PB), .STEP_DIV(SD_A)) dut_a (
    .clk(clk), .rst(rst_a), .req_in(req_a),
    .led_out(led_a), .level(level_a), .busy(busy_a)
  );

  led_fader #(.PWM_BITS(PB), .STEP_DIV(SD_B)) dut_b (
    .clk(clk), .rst(rst_b), .req_in(req_b),
    .led_out(led_b), .level(level_b), .busy(busy_b)
  );

  // Reference model. mode: 0 off, 1 rising, 2 full, 3 falling.
  typedef struct {
    int req_q;
    int mode;
    int level;
    int since;
    int pwm;
    int duty;
    int led;
    int busy;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int want_duty(int l);
`ifdef LED_FADER_GAMMA_EN
    if (l == MX) return MX;
    return (l * l) / 16;
`else
    return l;
`endif
  endfunction

  // One clock edge of the reference behaviour, given the inputs at that edge.
  function automatic mdl_t advance(mdl_t m, int sd, bit r, bit q);
    mdl_t n;
    bit   stepping;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    n = m;
    n.req_q  = q;
    stepping = ((m.since % sd) == sd - 1);
    n.since  = m.since + 1;
    n.pwm    = (m.pwm + 1) % 16;
    if (m.pwm == MX) n.duty = want_duty(m.level);
    n.led    = ((m.pwm < m.duty) || (m.duty == MX)) ? 1 : 0;
    if (m.mode == 0 && m.req_q == 1) begin
      n.mode = 1; n.since = 0;
    end else if (m.mode == 2 && m.req_q == 0) begin
      n.mode = 3; n.since = 0;
    end else if (m.mode == 1) begin
      if (m.req_q == 0) n.mode = 3;
      else if (stepping) begin
        n.level = (m.level < MX) ? m.level + 1 : MX;
        if (n.level == MX) n.mode = 2;
      end
    end else if (m.mode == 3) begin
      if (m.req_q == 1) n.mode = 1;
      else if (stepping) begin
        n.level = (m.level > 0) ? m.level - 1 : 0;
        if (n.level == 0) n.mode = 0;
      end
    end
    n.busy = (n.mode == 1 || n.mode == 3) ? 1 : 0;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Compare both DUTs against the model every cycle, then step the model.
  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("a_level", 32'(level_a), ma.level);
        chk("a_led",   32'(led_a),   ma.led);
        chk("a_busy",  32'(busy_a),  ma.busy);
        chk("b_level", 32'(level_b), mb.level);
        chk("b_led",   32'(led_b),   mb.led);
        chk("b_busy",  32'(busy_b),  mb.busy);
      end
      ma = advance(ma, SD_A, rst_a, req_a);
      mb = advance(mb, SD_B, rst_b, req_b);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    tick(3);
    armed = 1'b1;
    rst_a = 1'b0;

    // Idle: request low for 100 cycles.
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle_level", 32'(level_a), 0);
      chk("idle_led",   32'(led_a),   0);
      chk("idle_busy",  32'(busy_a),  0);
    end

    // Full ramp up.
    req_a = 1'b1;
    tick(1);  chk("up_e1_busy",  32'(busy_a), 0);
    tick(1);  chk("up_e2_busy",  32'(busy_a), 1);
              chk("up_e2_level", 32'(level_a), 0);
    tick(3);  chk("up_e5_level", 32'(level_a), 0);
    tick(1);  chk("up_e6_level", 32'(level_a), 1);
    tick(55); chk("up_e61_level", 32'(level_a), 14);
              chk("up_e61_busy",  32'(busy_a), 1);
    tick(1);  chk("up_e62_level", 32'(level_a), 15);
              chk("up_e62_busy",  32'(busy_a), 0);
    tick(32);
    for (int i = 0; i < 16; i++) begin
      tick(1); chk("on_led", 32'(led_a), 1);
    end

    // Full ramp down.
    req_a = 1'b0;
    tick(1);  chk("dn_e1_busy",  32'(busy_a), 0);
    tick(1);  chk("dn_e2_busy",  32'(busy_a), 1);
              chk("dn_e2_level", 32'(level_a), 15);
    tick(3);  chk("dn_e5_level", 32'(level_a), 15);
    tick(1);  chk("dn_e6_level", 32'(level_a), 14);
    tick(55); chk("dn_e61_level", 32'(level_a), 1);
    tick(1);  chk("dn_e62_level", 32'(level_a), 0);
              chk("dn_e62_busy",  32'(busy_a), 0);
    tick(32);
    for (int i = 0; i < 16; i++) begin
      tick(1); chk("off_led", 32'(led_a), 0);
    end

    // Reversals: up to 7, down to 3, back up.
    req_a = 1'b1;
    tick(30); chk("rv_e30_level", 32'(level_a), 7);
    req_a = 1'b0;
    tick(2);  chk("rv_e32_level", 32'(level_a), 7);
              chk("rv_e32_busy",  32'(busy_a), 1);
    tick(1);  chk("rv_e33_level", 32'(level_a), 7);
    tick(1);  chk("rv_e34_level", 32'(level_a), 6);
    tick(12); chk("rv_e46_level", 32'(level_a), 3);
    req_a = 1'b1;
    tick(2);  chk("rv_e48_level", 32'(level_a), 3);
              chk("rv_e48_busy",  32'(busy_a), 1);
    tick(1);  chk("rv_e49_level", 32'(level_a), 3);
    tick(1);  chk("rv_e50_level", 32'(level_a), 4);
    tick(20); chk("rv_e70_level", 32'(level_a), 9);

    // Reset in the middle of a ramp, request still high.
    rst_a = 1'b1;
    tick(1);  chk("rs_level", 32'(level_a), 0);
              chk("rs_led",   32'(led_a),   0);
              chk("rs_busy",  32'(busy_a),  0);
    rst_a = 1'b0;
    tick(1);  chk("rs_e1_busy",  32'(busy_a), 0);
    tick(1);  chk("rs_e2_busy",  32'(busy_a), 1);
    tick(3);  chk("rs_e5_level", 32'(level_a), 0);
    tick(1);  chk("rs_e6_level", 32'(level_a), 1);

    // PWM duty at steady levels 5 and 8 on the slow instance.
    rst_b = 1'b0;
    req_b = 1'b1;
    tick(321); chk("pw_e321_level", 32'(level_b), 4);
    tick(1);   chk("pw_e322_level", 32'(level_b), 5);
    tick(30);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1); cnt += int'(led_b);
    end
    chk("pwm_l5_high", 32'(cnt), EXP_HI5);
    tick(146); chk("pw_e514_level", 32'(level_b), 8);
    tick(30);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick(1); cnt += int'(led_b);
    end
    chk("pwm_l8_high", 32'(cnt), EXP_HI8);

    tick(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
